// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
//   slave  : the cache itself. It receives the PC, stall and flush, plus the
//            controller response. It drives the fetched instruction and the
//            controller request.
//   master : the surrounding pipeline and memory controller.
interface icache_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  branch_interception;
    logic [ADDR_WIDTH-1:0] pc_i;
    logic                  id_stall;
    logic [31:0]           inst_o;
    logic [ADDR_WIDTH-1:0] inst_addr_o;
    logic                  inst_valid_o;
    logic [ADDR_WIDTH-1:0] mc_addr_o;
    logic                  mc_stall_o;
    logic [31:0]           mc_inst_i;
    logic [ADDR_WIDTH-1:0] mc_inst_addr_i;
    logic                  mc_inst_valid_i;

    modport slave (
        input  branch_interception, pc_i, id_stall,
        input  mc_inst_i, mc_inst_addr_i, mc_inst_valid_i,
        output inst_o, inst_addr_o, inst_valid_o, mc_addr_o, mc_stall_o
    );

    modport master (
        output branch_interception, pc_i, id_stall,
        output mc_inst_i, mc_inst_addr_i, mc_inst_valid_i,
        input  inst_o, inst_addr_o, inst_valid_o, mc_addr_o, mc_stall_o
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache and fetch sequencer.
// It sits between pc_reg and the instruction port of the memory controller.
// A hit delivers the word one cycle after the PC is sampled. A miss sends the
// PC to the controller, waits for the response carrying the matching address,
// fills the line and then delivers the word. A branch interception drops any
// pending fetch and the current output, but the cache contents are kept.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : icache_fetch_if.slave. It carries:
//              - pc_i, id_stall and branch_interception from the pipeline;
//              - inst_o, inst_addr_o and inst_valid_o to the IF/ID register;
//              - mc_addr_o and mc_stall_o to the memory controller;
//              - mc_inst_i, mc_inst_addr_i and mc_inst_valid_i from it.
module icache_fetch #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    // Line storage. Only the valid bits need a reset.
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];
    logic [LINES-1:0]    line_valid_reg;
    logic [LINES-1:0]    fill_sel;

    state_t                state_reg, state_next;
    logic [31:0]           inst_reg, inst_next;
    logic [ADDR_WIDTH-1:0] inst_addr_reg, inst_addr_next;
    logic                  inst_valid_reg, inst_valid_next;
    logic [ADDR_WIDTH-1:0] mc_addr_reg, mc_addr_next;
    logic [ADDR_WIDTH-1:0] pend_addr_reg, pend_addr_next;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  lookup_hit;
    logic [31:0]           lookup_data;

    assign lookup_idx = bus.pc_i[INDEX_BITS+1:2];
    assign lookup_tag = bus.pc_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_idx   = bus.mc_inst_addr_i[INDEX_BITS+1:2];
    assign fill_tag   = bus.mc_inst_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];

    // The lookup reads the arrays before the clock edge. A fill to the same
    // index in the same cycle is therefore not visible yet. The lookup sees
    // the old line, and a resulting miss simply refetches.
    assign lookup_hit  = line_valid_reg[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign lookup_data = data_mem[lookup_idx];

    // Every response fills its line, whatever the state. This includes
    // stale responses and responses that arrive during a flush. Program
    // text is read-only, so a stale fill still holds correct data.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_fill_sel
            assign fill_sel[gi] = bus.mc_inst_valid_i && (fill_idx == INDEX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (bus.mc_inst_valid_i) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.mc_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_reg <= '0;
        end else begin
            line_valid_reg <= line_valid_reg | fill_sel;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            inst_reg       <= '0;
            inst_addr_reg  <= '0;
            inst_valid_reg <= 1'b0;
            mc_addr_reg    <= '0;
            pend_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            inst_reg       <= inst_next;
            inst_addr_reg  <= inst_addr_next;
            inst_valid_reg <= inst_valid_next;
            mc_addr_reg    <= mc_addr_next;
            pend_addr_reg  <= pend_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        inst_next       = inst_reg;
        inst_addr_next  = inst_addr_reg;
        inst_valid_next = inst_valid_reg;
        mc_addr_next    = mc_addr_reg;
        pend_addr_next  = pend_addr_reg;

        if (bus.branch_interception) begin
            // Flush. The pending address is simply forgotten. A late
            // response can only fill the cache, because IDLE never compares
            // against pend_addr.
            inst_valid_next = 1'b0;
            state_next      = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // The slot is free, or IF/ID consumes it this cycle.
                    // Otherwise hold everything and ignore pc_i.
                    if (!inst_valid_reg || !bus.id_stall) begin
                        if (lookup_hit) begin
                            inst_next       = lookup_data;
                            inst_addr_next  = bus.pc_i;
                            inst_valid_next = 1'b1;
                        end else begin
                            inst_valid_next = 1'b0;
                            mc_addr_next    = bus.pc_i;
                            pend_addr_next  = bus.pc_i;
                            state_next      = MISS;
                        end
                    end
                end
                MISS: begin
                    // A response for any other address is stale: it fills
                    // the cache only, and the fetch keeps waiting.
                    if (bus.mc_inst_valid_i && (bus.mc_inst_addr_i == pend_addr_reg)) begin
                        inst_next       = bus.mc_inst_i;
                        inst_addr_next  = pend_addr_reg;
                        inst_valid_next = 1'b1;
                        state_next      = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.inst_o       = inst_reg;
    assign bus.inst_addr_o  = inst_addr_reg;
    assign bus.inst_valid_o = inst_valid_reg;
    assign bus.mc_addr_o    = mc_addr_reg;
    assign bus.mc_stall_o   = (state_reg != MISS);
endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_fetch_if #(.ADDR_WIDTH(32)) bus ();

    icache_fetch #(
        .INDEX_BITS(7),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Read-only program image served by the controller model.
    function automatic logic [31:0] prog(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Reference model. The cache is kept as "which word address lives in
    // each slot". The fetch is kept as "is a fetch outstanding, and for
    // which address".
    bit          c_valid [128];
    logic [31:0] c_addr  [128];
    logic [31:0] c_data  [128];
    bit          m_valid;
    logic [31:0] m_inst, m_addr, m_mcaddr, m_pend;
    bit          m_waiting;

    // Memory-controller model: one outstanding request and a fixed or
    // random latency.
    bit          r_busy = 0;
    int          r_cnt = 0;
    logic [31:0] r_addr = '0;
    int          lat_cfg = 6;

    task automatic model_step();
        int   i;
        logic [31:0] pc;
        pc = bus.pc_i;
        if (rst) begin
            foreach (c_valid[k]) c_valid[k] = 0;
            m_valid = 0; m_inst = 0; m_addr = 0; m_mcaddr = 0; m_pend = 0; m_waiting = 0;
            return;
        end
        i = int'((pc >> 2) % 128);
        if (bus.branch_interception) begin
            m_valid = 0;
            m_waiting = 0;
        end else if (!m_waiting) begin
            if (!m_valid || !bus.id_stall) begin
                if (c_valid[i] && (c_addr[i] >> 2) == (pc >> 2)) begin
                    m_inst = c_data[i]; m_addr = pc; m_valid = 1;
                    $display("fetch hit  addr=%h inst=%h", pc, m_inst);
                end else begin
                    m_valid = 0; m_mcaddr = pc; m_pend = pc; m_waiting = 1;
                end
            end
        end else if (bus.mc_inst_valid_i && bus.mc_inst_addr_i == m_pend) begin
            m_inst = bus.mc_inst_i; m_addr = m_pend; m_valid = 1; m_waiting = 0;
            $display("fetch fill addr=%h inst=%h", m_pend, m_inst);
        end
        if (bus.mc_inst_valid_i) begin
            i = int'((bus.mc_inst_addr_i >> 2) % 128);
            c_valid[i] = 1;
            c_addr[i]  = bus.mc_inst_addr_i;
            c_data[i]  = bus.mc_inst_i;
        end
    endtask

    task automatic cycle();
        bit pulsed;
        @(negedge clk);
        pulsed = r_busy && (r_cnt == 0);
        if (pulsed) begin
            bus.mc_inst_valid_i = 1'b1;
            bus.mc_inst_addr_i  = r_addr;
            bus.mc_inst_i       = prog(r_addr);
        end else begin
            bus.mc_inst_valid_i = 1'b0;
            bus.mc_inst_addr_i  = $urandom & 32'hFFFF_FFFC;
            bus.mc_inst_i       = $urandom;
        end
        model_step();
        @(posedge clk);
        #1;
        check("inst_valid_o", {31'b0, bus.inst_valid_o}, {31'b0, m_valid});
        check("inst_o", bus.inst_o, m_inst);
        check("inst_addr_o", bus.inst_addr_o, m_addr);
        check("mc_addr_o", bus.mc_addr_o, m_mcaddr);
        check("mc_stall_o", {31'b0, bus.mc_stall_o}, {31'b0, !m_waiting});
        if (pulsed) r_busy = 0;
        if (!r_busy && !bus.mc_stall_o) begin
            r_busy = 1;
            r_addr = bus.mc_addr_o;
            r_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg;
        end else if (r_busy) begin
            r_cnt--;
        end
    endtask

    task automatic run_until_valid(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            cycle();
            if (bus.inst_valid_o) return;
        end
        check("fetch_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.branch_interception = 1'b0;
        bus.pc_i = '0;
        bus.id_stall = 1'b0;
        bus.mc_inst_i = '0;
        bus.mc_inst_addr_i = '0;
        bus.mc_inst_valid_i = 1'b0;
        cycle();
        cycle();
        check("rst_inst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
        check("rst_mc_stall", {31'b0, bus.mc_stall_o}, 32'd1);
        rst = 1'b0;

        // Cold miss.
        bus.pc_i = 32'h0;
        cycle();
        check("cold_miss_stall", {31'b0, bus.mc_stall_o}, 32'd0);
        run_until_valid(20);
        check("cold_inst", bus.inst_o, 32'h0000_0093);
        check("cold_addr", bus.inst_addr_o, 32'h0);
        check("cold_done_stall", {31'b0, bus.mc_stall_o}, 32'd1);

        // Hit.
        cycle();
        check("hit_valid", {31'b0, bus.inst_valid_o}, 32'd1);
        check("hit_no_miss", {31'b0, bus.mc_stall_o}, 32'd1);

        // Conflict on index 0.
        bus.pc_i = 32'h200;
        cycle();
        check("conflict_miss", {31'b0, bus.mc_stall_o}, 32'd0);
        run_until_valid(20);
        bus.pc_i = 32'h0;
        cycle();
        check("conflict_refetch", {31'b0, bus.mc_stall_o}, 32'd0);
        run_until_valid(20);

        // Stall hold while the PC wanders.
        cycle();
        bus.id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.pc_i = $urandom & 32'h0000_0FFC;
            cycle();
        end
        check("stall_hold_addr", bus.inst_addr_o, 32'h0);
        bus.id_stall = 1'b0;
        bus.pc_i = 32'h0;
        cycle();

        // Branch during a miss.
        bus.pc_i = 32'h40;
        run_until_valid(20);
        bus.pc_i = 32'h100;
        cycle();
        cycle();
        bus.branch_interception = 1'b1;
        bus.pc_i = 32'h40;
        cycle();
        bus.branch_interception = 1'b0;
        cycle();
        check("br_deliver_addr", bus.inst_addr_o, 32'h40);
        for (int k = 0; k < 10; k++) cycle();
        bus.pc_i = 32'h100;
        cycle();
        check("late_fill_hit_stall", {31'b0, bus.mc_stall_o}, 32'd1);
        check("late_fill_hit_addr", bus.inst_addr_o, 32'h100);

        // Reset mid-miss.
        bus.pc_i = 32'h300;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_mid_stall", {31'b0, bus.mc_stall_o}, 32'd1);
        check("rst_mid_mc_addr", bus.mc_addr_o, 32'h0);
        rst = 1'b0;
        bus.pc_i = 32'h0;
        cycle();
        check("rst_then_miss", {31'b0, bus.mc_stall_o}, 32'd0);
        run_until_valid(40);

        // Randomized traffic over a few tags that share a few indexes.
        lat_cfg = 0;
        for (int n = 0; n < 3000; n++) begin
            bus.pc_i = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2);
            bus.id_stall = ($urandom_range(0, 9) < 3);
            bus.branch_interception = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
